// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel enable, sync/blank flags and DrawX/DrawY scan counters.
// Optional macro VGA_SYNC_ALIGN_EN delays hs/vs by one pixel to line up with registered RGB.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       CLK,
    input  logic       Reset,
    output logic       pixel_ce,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Region bounds are 11 bits so an end bound of exactly 1024 stays representable.
    localparam logic [10:0] H_ACT_END = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;
    logic             line_end;
    logic             frame_end;
    logic             hs_nxt;
    logic             vs_nxt;
    logic             blank_nxt;
    logic             hs_raw;
    logic             vs_raw;

    assign pixel_ce = (div == DIV_LAST);

    always_comb begin
        x_nxt     = DrawX;
        y_nxt     = DrawY;
        line_end  = (DrawX == H_LAST);
        frame_end = line_end && (DrawY == V_LAST);
        if (pixel_ce) begin
            if (line_end) begin
                x_nxt = '0;
                y_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
            end else begin
                x_nxt = DrawX + 10'd1;
            end
        end
    end

    // Flags are decoded from the next counter values so they land on the same edge as the counters.
    assign hs_nxt    = !(({1'b0, x_nxt} >= HS_START) && ({1'b0, x_nxt} < HS_END));
    assign vs_nxt    = !(({1'b0, y_nxt} >= VS_START) && ({1'b0, y_nxt} < VS_END));
    assign blank_nxt = ({1'b0, x_nxt} < H_ACT_END) && ({1'b0, y_nxt} < V_ACT_END);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            div         <= '0;
            DrawX       <= '0;
            DrawY       <= '0;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div         <= pixel_ce ? '0 : div + DIV_W'(1);
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            hs_raw      <= hs_nxt;
            vs_raw      <= vs_nxt;
            blank       <= blank_nxt;
            frame_start <= pixel_ce && frame_end;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic hs_dly;
    logic vs_dly;

    // One pixel of extra delay on the syncs only; blank and the counters stay zero-skew.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            hs_dly <= 1'b1;
            vs_dly <= 1'b1;
        end else if (pixel_ce) begin
            hs_dly <= hs_raw;
            vs_dly <= vs_raw;
        end
    end

    assign hs = hs_dly;
    assign vs = vs_dly;
`else
    assign hs = hs_raw;
    assign vs = vs_raw;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench for vga_timing_gen: three instances (640x480 /2, small raster /2, small /1)
// compared every cycle against a closed-form raster model derived from elapsed pixel count.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_full  = 1'b1;
    logic rst_small = 1'b1;
    logic rst_div1  = 1'b1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected outputs after t rising edges with reset low, packed as {ce,hs,vs,blank,fs,x,y}.
    function automatic logic [24:0] model(input int t, input int hv, input int hf, input int hsw,
                                          input int hb, input int vv, input int vf, input int vsw,
                                          input int vb, input int cd);
        int ht, vt, p, x, y, xs, ys, q;
        logic ce, h, v, bl, fs;
        logic [9:0] xo, yo;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        p  = t / cd;
        x  = p % ht;
        y  = (p / ht) % vt;
        ce = ((t % cd) == cd - 1);
        bl = (x < hv) && (y < vv);
        xs = x;
        ys = y;
`ifdef VGA_SYNC_ALIGN_EN
        if (p == 0) begin
            xs = 0;
            ys = 0;
        end else begin
            q  = p - 1;
            xs = q % ht;
            ys = (q / ht) % vt;
        end
`endif
        h  = !((xs >= hv + hf) && (xs < hv + hf + hsw));
        v  = !((ys >= vv + vf) && (ys < vv + vf + vsw));
        fs = (p > 0) && ((p % (ht * vt)) == 0) && ((t % cd) == 0);
        xo = 10'(x);
        yo = 10'(y);
        return {ce, h, v, bl, fs, xo, yo};
    endfunction

    // DUT instances
    logic       ce_f, hs_f, vs_f, bl_f, fs_f;
    logic [9:0] x_f, y_f;
    logic       ce_s, hs_s, vs_s, bl_s, fs_s;
    logic [9:0] x_s, y_s;
    logic       ce_1, hs_1, vs_1, bl_1, fs_1;
    logic [9:0] x_1, y_1;

    vga_timing_gen u_full (
        .CLK(clk), .Reset(rst_full), .pixel_ce(ce_f), .hs(hs_f), .vs(vs_f),
        .blank(bl_f), .DrawX(x_f), .DrawY(y_f), .frame_start(fs_f)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(2)
    ) u_small (
        .CLK(clk), .Reset(rst_small), .pixel_ce(ce_s), .hs(hs_s), .vs(vs_s),
        .blank(bl_s), .DrawX(x_s), .DrawY(y_s), .frame_start(fs_s)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(1)
    ) u_div1 (
        .CLK(clk), .Reset(rst_div1), .pixel_ce(ce_1), .hs(hs_1), .vs(vs_1),
        .blank(bl_1), .DrawX(x_1), .DrawY(y_1), .frame_start(fs_1)
    );

    // Elapsed-edge counters for the model
    int t_full = 0, t_small = 0, t_div1 = 0;
    always @(posedge clk or posedge rst_full)  t_full  <= rst_full  ? 0 : t_full + 1;
    always @(posedge clk or posedge rst_small) t_small <= rst_small ? 0 : t_small + 1;
    always @(posedge clk or posedge rst_div1)  t_div1  <= rst_div1  ? 0 : t_div1 + 1;

    // Per-cycle comparison plus period measurements
    int         cyc = 0;
    int         last_line_f = -1, last_frame_s = -1, last_line_1 = -1;
    int         n_line_f = 0, n_frame_s = 0, n_line_1 = 0, n_hs_runs = 0;
    int         hs_low_cnt = 0;
    logic [9:0] prev_x_f = '0, prev_x_1 = '0;

    always @(negedge clk) begin
        cyc++;
        check("full",  32'({ce_f, hs_f, vs_f, bl_f, fs_f, x_f, y_f}),
              32'(model(t_full, 640, 16, 96, 48, 480, 10, 2, 33, 2)));
        check("small", 32'({ce_s, hs_s, vs_s, bl_s, fs_s, x_s, y_s}),
              32'(model(t_small, 16, 4, 6, 6, 10, 2, 2, 3, 2)));
        check("div1",  32'({ce_1, hs_1, vs_1, bl_1, fs_1, x_1, y_1}),
              32'(model(t_div1, 16, 4, 6, 6, 10, 2, 2, 3, 1)));

        if (rst_full) begin
            last_line_f = -1;
            hs_low_cnt  = 0;
        end else begin
            if (prev_x_f == 10'd799 && x_f == 10'd0) begin
                if (last_line_f >= 0) begin
                    check("line_period_full", 32'(cyc - last_line_f), 32'd1600);
                    n_line_f++;
                end
                last_line_f = cyc;
            end
            if (hs_f == 1'b0) begin
                hs_low_cnt++;
            end else if (hs_low_cnt != 0) begin
                check("hs_low_cycles_full", 32'(hs_low_cnt), 32'd192);
                n_hs_runs++;
                hs_low_cnt = 0;
            end
        end

        if (rst_small) begin
            last_frame_s = -1;
        end else if (fs_s) begin
            if (last_frame_s >= 0) begin
                check("frame_period_small", 32'(cyc - last_frame_s), 32'd1088);
                n_frame_s++;
            end
            last_frame_s = cyc;
        end

        if (rst_div1) begin
            last_line_1 = -1;
        end else if (prev_x_1 == 10'd31 && x_1 == 10'd0) begin
            if (last_line_1 >= 0) begin
                check("line_period_div1", 32'(cyc - last_line_1), 32'd32);
                n_line_1++;
            end
            last_line_1 = cyc;
        end

        prev_x_f = x_f;
        prev_x_1 = x_1;
    end

    initial begin
        int  waited;
        logic hit;

        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        rst_full  = 1'b0;
        rst_small = 1'b0;
        rst_div1  = 1'b0;

        // Run the full raster into line 1, pixel 700, then reset asynchronously mid-cycle
        hit    = 1'b0;
        waited = 0;
        while (!hit && waited < 6000) begin
            @(negedge clk);
            waited++;
            if (x_f == 10'd700 && y_f == 10'd1) hit = 1'b1;
        end
        check("reach_700_1", 32'(hit), 32'd1);

        @(posedge clk);
        #2;
        rst_full = 1'b1;
        #1;
        check("async_rst_x",     32'(x_f),  32'd0);
        check("async_rst_y",     32'(y_f),  32'd0);
        check("async_rst_hs",    32'(hs_f), 32'd1);
        check("async_rst_vs",    32'(vs_f), 32'd1);
        check("async_rst_blank", 32'(bl_f), 32'd1);
        check("async_rst_fs",    32'(fs_f), 32'd0);
        check("async_rst_ce",    32'(ce_f), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        rst_full = 1'b0;
        repeat (3300) @(negedge clk);

        // Random asynchronous reset pulses on the small raster
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(300, 1500)) @(posedge clk);
            #($urandom_range(1, 4));
            rst_small = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #($urandom_range(1, 4));
            rst_small = 1'b0;
        end
        repeat (2400) @(negedge clk);

        check("line_periods_seen_full",  32'(n_line_f  > 0), 32'd1);
        check("hs_runs_seen_full",       32'(n_hs_runs > 0), 32'd1);
        check("frame_periods_seen_small", 32'(n_frame_s > 0), 32'd1);
        check("line_periods_seen_div1",  32'(n_line_1  > 0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
